// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin arbiter and load sequencer for a shared PIPO register; define PIPO_ARB_CLR_EN to enable the clr pulse
module pipo_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      p_out,
    output logic                  ld,
    output logic                  busy,
    output logic                  clr
);
    localparam int LW = $clog2(NREQ);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  p_q, p_d;
    logic              ld_q, ld_d;
    logic [LW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     win;
    logic              found;
    logic              hold_end;

    assign hold_end = (state_q == ST_HOLD) && (cnt_q == '0);
    assign gnt      = gnt_q;
    assign p_out    = p_q;
    assign ld       = ld_q;
    assign busy     = state_q != ST_IDLE;
    assign ack      = hold_end ? gnt_q : '0;

    // round-robin search starting one past the last winner, then FSM next-state and registered outputs
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        p_d     = p_q;
        ld_d    = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;
        win     = last_q;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(last_q) + i) % NREQ]) begin
                win   = LW'((int'(last_q) + i) % NREQ);
                found = 1'b1;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOAD;
                    gnt_d   = NREQ'(1) << win;
                    p_d     = data_in[win*WIDTH +: WIDTH];
                    ld_d    = 1'b1;
                    last_d  = win;
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
                cnt_d   = CW'(HOLD - 1);
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers; reset discards any in-flight grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            p_q     <= '0;
            ld_q    <= 1'b0;
            last_q  <= LW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            p_q     <= p_d;
            ld_q    <= ld_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPO_ARB_CLR_EN
    logic clr_q, clr_d;
    assign clr_d = hold_end;
    assign clr   = clr_q;
    // clear pulse lands in the idle cycle right after each ack
    always_ff @(posedge clk) begin
        if (rst) clr_q <= 1'b0;
        else     clr_q <= clr_d;
    end
`else
    assign clr = 1'b0;
`endif
endmodule

// File: tb/tb_pipo_arbiter.sv
// tb_pipo_arbiter: table-driven scoreboard bench for pipo_arbiter
module tb_pipo_arbiter;
    localparam int NREQ = 4, WIDTH = 4, HOLD = 2;
`ifdef PIPO_ARB_CLR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] data_in = '0;
    logic [3:0]  gnt, ack, p_out;
    logic        ld, busy, clr;

    pipo_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .ack(ack), .p_out(p_out), .ld(ld), .busy(busy), .clr(clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] ack;
        logic [3:0] p;
        logic       ld;
        logic       busy;
        logic       clr;
    } out_t;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] data;
        out_t        exp;
    } vec_t;

    vec_t v[$];
    out_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input logic r, input logic [3:0] rq, input logic [15:0] d,
                                input logic [3:0] g, input logic [3:0] a, input logic [3:0] p,
                                input logic l, input logic b, input logic c);
        out_t o;
        o.gnt = g; o.ack = a; o.p = p; o.ld = l; o.busy = b; o.clr = c & CLR;
        v.push_back('{r, rq, d, o});
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] W4 = 16'hFD9C;
    localparam logic [15:0] W1 = 16'h0900;

    initial begin
        int n;
        out_t e;
        // reset held with all requests pending
        add(1, 4'b1111, W4, 4'b0000, 4'b0000, 4'h0, 0, 0, 0);
        add(1, 4'b1111, W4, 4'b0000, 4'b0000, 4'h0, 0, 0, 0);
        // round-robin 0,1,2,3,0
        add(0, 4'b1111, W4, 4'b0001, 4'b0000, 4'hC, 1, 1, 0);
        add(0, 4'b1111, W4, 4'b0001, 4'b0000, 4'hC, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0001, 4'b0001, 4'hC, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0000, 4'b0000, 4'hC, 0, 0, 1);
        add(0, 4'b1111, W4, 4'b0010, 4'b0000, 4'h9, 1, 1, 0);
        add(0, 4'b1111, W4, 4'b0010, 4'b0000, 4'h9, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0010, 4'b0010, 4'h9, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0000, 4'b0000, 4'h9, 0, 0, 1);
        add(0, 4'b1111, W4, 4'b0100, 4'b0000, 4'hD, 1, 1, 0);
        add(0, 4'b1111, W4, 4'b0100, 4'b0000, 4'hD, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0100, 4'b0100, 4'hD, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0000, 4'b0000, 4'hD, 0, 0, 1);
        add(0, 4'b1111, W4, 4'b1000, 4'b0000, 4'hF, 1, 1, 0);
        add(0, 4'b1111, W4, 4'b1000, 4'b0000, 4'hF, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b1000, 4'b1000, 4'hF, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0000, 4'b0000, 4'hF, 0, 0, 1);
        add(0, 4'b1111, W4, 4'b0001, 4'b0000, 4'hC, 1, 1, 0);
        add(0, 4'b1111, W4, 4'b0001, 4'b0000, 4'hC, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0001, 4'b0001, 4'hC, 0, 1, 0);
        add(0, 4'b1111, W4, 4'b0000, 4'b0000, 4'hC, 0, 0, 1);
        // requester 1 drops req mid-grant, still acked; pointer then favours 3 over 0
        add(0, 4'b0010, W4, 4'b0010, 4'b0000, 4'h9, 1, 1, 0);
        add(0, 4'b0000, W4, 4'b0010, 4'b0000, 4'h9, 0, 1, 0);
        add(0, 4'b0000, W4, 4'b0010, 4'b0010, 4'h9, 0, 1, 0);
        add(0, 4'b1001, W4, 4'b0000, 4'b0000, 4'h9, 0, 0, 1);
        add(0, 4'b1001, W4, 4'b1000, 4'b0000, 4'hF, 1, 1, 0);
        add(0, 4'b0000, W4, 4'b1000, 4'b0000, 4'hF, 0, 1, 0);
        add(0, 4'b0000, W4, 4'b1000, 4'b1000, 4'hF, 0, 1, 0);
        add(0, 4'b0000, W4, 4'b0000, 4'b0000, 4'hF, 0, 0, 1);
        // reset during LOAD discards the grant; requester 0 regains priority
        add(0, 4'b0010, W4, 4'b0010, 4'b0000, 4'h9, 1, 1, 0);
        add(1, 4'b0011, W4, 4'b0000, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 4'b0011, W4, 4'b0001, 4'b0000, 4'hC, 1, 1, 0);
        add(0, 4'b0000, W4, 4'b0001, 4'b0000, 4'hC, 0, 1, 0);
        add(0, 4'b0000, W4, 4'b0001, 4'b0001, 4'hC, 0, 1, 0);
        add(0, 4'b0000, W4, 4'b0000, 4'b0000, 4'hC, 0, 0, 1);
        add(0, 4'b0000, W4, 4'b0000, 4'b0000, 4'hC, 0, 0, 0);
        // single requester 2 with word 1001
        add(0, 4'b0100, W1, 4'b0100, 4'b0000, 4'h9, 1, 1, 0);
        add(0, 4'b0000, W1, 4'b0100, 4'b0000, 4'h9, 0, 1, 0);
        add(0, 4'b0000, W1, 4'b0100, 4'b0100, 4'h9, 0, 1, 0);
        add(0, 4'b0000, W1, 4'b0000, 4'b0000, 4'h9, 0, 0, 1);
        add(0, 4'b0000, W1, 4'b0000, 4'b0000, 4'h9, 0, 0, 0);

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            rst = v[i].rst;
            req = v[i].req;
            data_in = v[i].data;
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front();
            check($sformatf("vec%0d", i), 32'({gnt, ack, p_out, ld, busy, clr}), 32'(e));
        end

        // hand sequence: lone requester 3, bounded wait for ld, then ack latency
        @(negedge clk);
        req = 4'b1000;
        data_in = W4;
        n = 0;
        tick();
        while (!ld && n < 10) begin
            tick();
            n++;
        end
        check("seq_ld_seen", 32'(ld), 32'(1));
        check("seq_load", 32'({gnt, p_out, busy}), 32'({4'b1000, 4'hF, 1'b1}));
        @(negedge clk);
        req = 4'b0000;
        n = 0;
        while (ack == 4'b0000 && n < 10) begin
            tick();
            n++;
        end
        check("seq_ack_lat", 32'(n), 32'(HOLD));
        check("seq_ack", 32'({ack, gnt}), 32'({4'b1000, 4'b1000}));
        tick();
        check("seq_release", 32'({gnt, ack, busy, clr}), 32'({4'b0000, 4'b0000, 1'b0, CLR}));
        tick();
        check("seq_idle", 32'({gnt, ld, busy, clr, p_out}), 32'({4'b0000, 1'b0, 1'b0, 1'b0, 4'hF}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
